// File: rtl/psr_flag_requester.sv
// PSR flag-update requester: derives N/V/Z/C from an ALU result
// and delivers it to the status register over a four-phase handshake.
module psr_flag_requester #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [2:0] flag_class,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [7:0] mem_operand,
  input  logic       n_cur,
  input  logic       v_cur,
  input  logic       z_cur,
  input  logic       c_cur,
  output logic       psr_update_request,
  output logic       n_result,
  output logic       v_result,
  output logic       z_result,
  output logic       c_result,
  input  logic       ack_update_request,
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  flags_t           flags_q;
  flags_t           flags_d;

  logic cls_nz;
  logic cls_nzvc;
  logic cls_nzc;
  logic cls_bit;
  logic cls_bitz;
  logic class_ok;
  logic res_zero;
  logic accept;
  logic cnt_last;

  // Low bits of the memory operand never feed a flag.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_operand[5:0];

  assign res_zero = (alu_result == 8'h00);
  assign class_ok = (flag_class <= 3'd4);
  assign cnt_last = (cnt == CNT_LAST);

  // Ready is registered and also requires ack low on the
  // previous edge, so a stale ack never meets a new request.
  assign accept = (state == IDLE) && alu_ready && alu_valid;

  // One-hot decode of the flag class.
  always_comb begin
    cls_nz   = (flag_class == 3'd0);
    cls_nzvc = (flag_class == 3'd1);
    cls_nzc  = (flag_class == 3'd2);
    cls_bit  = (flag_class == 3'd3);
    cls_bitz = (flag_class == 3'd4);
  end

  // Per-class flag derivation; flags the class does not
  // write pass the current PSR value straight through.
  always_comb begin
    flags_d.n = n_cur;
    flags_d.v = v_cur;
    flags_d.z = z_cur;
    flags_d.c = c_cur;
    unique case (1'b1)
      cls_nz: begin
        flags_d.n = alu_result[7];
        flags_d.z = res_zero;
      end
      cls_nzvc: begin
        flags_d.n = alu_result[7];
        flags_d.v = alu_overflow;
        flags_d.z = res_zero;
        flags_d.c = alu_carry;
      end
      cls_nzc: begin
        flags_d.n = alu_result[7];
        flags_d.z = res_zero;
        flags_d.c = alu_carry;
      end
      cls_bit: begin
        flags_d.n = mem_operand[7];
        flags_d.v = mem_operand[6];
        flags_d.z = res_zero;
      end
      cls_bitz: begin
        flags_d.z = res_zero;
      end
      default: begin
      end
    endcase
  end

  // Handshake FSM with registered request, flags, ready,
  // timeout counter and sticky error.
  always_ff @(posedge fclk) begin
    if (!resb) begin
      state              <= IDLE;
      cnt                <= '0;
      flags_q            <= '0;
      psr_update_request <= 1'b0;
      alu_ready          <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept && class_ok) begin
            state              <= REQ;
            cnt                <= '0;
            flags_q            <= flags_d;
            psr_update_request <= 1'b1;
            alu_ready          <= 1'b0;
          end else begin
            alu_ready <= !ack_update_request;
          end
        end
        REQ: begin
          if (ack_update_request) begin
            state              <= RELEASE;
            cnt                <= '0;
            psr_update_request <= 1'b0;
          end else if (cnt_last) begin
            state              <= IDLE;
            cnt                <= '0;
            psr_update_request <= 1'b0;
            timeout_err        <= 1'b1;
            alu_ready          <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_update_request) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_ready <= 1'b1;
          end else if (cnt_last) begin
            state       <= IDLE;
            cnt         <= '0;
            timeout_err <= 1'b1;
            alu_ready   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state              <= IDLE;
          cnt                <= '0;
          psr_update_request <= 1'b0;
        end
      endcase
    end
  end

  assign n_result = flags_q.n;
  assign v_result = flags_q.v;
  assign z_result = flags_q.z;
  assign c_result = flags_q.c;

endmodule
